// File: rtl/cic_sched.sv
// Rate scheduler for the CIC interpolator: fetches one source sample per input
// period, emits input/output-rate strobes, clears the chain on start and drains it on stop.
module cic_sched #(
  parameter int DIN_W         = 8,
  parameter int IN_DIV        = 64,
  parameter int OUT_DIV       = 4,
  parameter int FLUSH_PERIODS = 4
) (
  input  logic             sclk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             clear_err,
  output logic             src_req,
  input  logic [DIN_W-1:0] src_data,
  input  logic             src_v,
  output logic             cic_clr,
  output logic [DIN_W-1:0] cic_din,
  output logic             cic_din_v,
  output logic             cic_dout_v,
  output logic             busy,
  output logic             underrun
);

  localparam int PH_W = (IN_DIV > 1) ? $clog2(IN_DIV) : 1;
  localparam int FC_W = (FLUSH_PERIODS > 1) ? $clog2(FLUSH_PERIODS) : 1;

  typedef enum logic [1:0] {IDLE, CLR, RUN, FLUSH} state_t;

  state_t                  state, state_n;
  logic [PH_W-1:0]         phase, phase_n;
  logic [FC_W-1:0]         fcnt, fcnt_n;
  logic                    pend, pend_n;
  logic                    got, got_n;
  logic signed [DIN_W-1:0] hold, hold_n;
  logic                    last, take, active_n;
  logic                    req_n, clr_n, din_v_n, dout_v_n, underrun_n;
  logic [DIN_W-1:0]        din_n;

  always_comb begin
    state_n    = state;
    phase_n    = phase;
    fcnt_n     = fcnt;
    pend_n     = pend;
    got_n      = got;
    hold_n     = hold;
    underrun_n = clear_err ? 1'b0 : underrun;
    last       = (phase == PH_W'(IN_DIV - 1));
    take       = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) state_n = CLR;
      end
      CLR: begin
        hold_n  = '0;
        phase_n = '0;
        got_n   = 1'b0;
        pend_n  = 1'b0;
        state_n = RUN;
      end
      RUN: begin
        phase_n = last ? '0 : phase + 1'b1;
        take    = src_v && !got && (phase != '0);
        if (take) begin
          hold_n = src_data;
          got_n  = 1'b1;
        end
        if (stop) pend_n = 1'b1;
        if (last) begin
          got_n = 1'b0;
          // A sample arriving in the final phase still counts; the miss is judged after it.
          if (!got && !take) begin
            underrun_n = 1'b1;
            hold_n     = '0;
          end
          if (pend || stop) begin
            state_n = FLUSH;
            fcnt_n  = '0;
            pend_n  = 1'b0;
          end
        end
      end
      FLUSH: begin
        phase_n = last ? '0 : phase + 1'b1;
        if (last) begin
          if (fcnt == FC_W'(FLUSH_PERIODS - 1)) state_n = IDLE;
          else                                  fcnt_n  = fcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // Outputs are registered, so they are derived from the upcoming state and phase.
    active_n = (state_n == RUN) || (state_n == FLUSH);
    din_v_n  = active_n && (phase_n == '0);
    req_n    = (state_n == RUN) && (phase_n == '0);
    din_n    = req_n ? hold_n : '0;
    dout_v_n = active_n && ((32'(phase_n) % 32'(OUT_DIV)) == 32'd0);
    clr_n    = (state_n == CLR);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= '0;
      fcnt       <= '0;
      pend       <= 1'b0;
      got        <= 1'b0;
      hold       <= '0;
      src_req    <= 1'b0;
      cic_clr    <= 1'b0;
      cic_din    <= '0;
      cic_din_v  <= 1'b0;
      cic_dout_v <= 1'b0;
      busy       <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      state      <= state_n;
      phase      <= phase_n;
      fcnt       <= fcnt_n;
      pend       <= pend_n;
      got        <= got_n;
      hold       <= hold_n;
      src_req    <= req_n;
      cic_clr    <= clr_n;
      cic_din    <= din_n;
      cic_din_v  <= din_v_n;
      cic_dout_v <= dout_v_n;
      busy       <= (state_n != IDLE);
      underrun   <= underrun_n;
    end
  end

endmodule
